ex_mem_stage: RTL and testbench

- Pipeline register between the execute stage (ALU) and the memory stage of the RV32I core.
- Captures the ALU result and the instruction's control bits.
- Resolves branches and jumps from the ALU zero flag and computes the redirect target.
- After a taken control transfer, drops the wrong-path instructions that follow it into EX.

---
 rtl/ex_mem_stage.sv | 156 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the RV32I core: captures ALU result and controls,
// resolves branches/jumps into a one-cycle redirect and squashes the wrong-path slots behind it.
module ex_mem_stage #(
    parameter int XLEN         = 32,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            zero_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    input  logic            branch_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [2:0]      funct3_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [4:0]      rd_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            mem_to_reg_o,
    output logic [2:0]      funct3_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    localparam int              CW      = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);
    localparam logic [CW-1:0]   SQ_LOAD = CW'(SQUASH_DEPTH);
    localparam int              NCTRL   = 4;

    logic            valid_reg,      valid_next;
    logic [XLEN-1:0] result_reg,     result_next;
    logic [XLEN-1:0] store_data_reg, store_data_next;
    logic [4:0]      rd_reg,         rd_next;
    logic [2:0]      funct3_reg,     funct3_next;
    logic            redirect_reg,   redirect_next;
    logic [XLEN-1:0] target_reg,     target_next;
    logic            misaligned_reg, misaligned_next;
    logic [CW-1:0]   squash_reg,     squash_next;
    logic [NCTRL-1:0] ctrl_reg,      ctrl_next;

    logic             squashing;
    logic             accept_insn;
    logic             taken;
    logic [XLEN-1:0]  target_calc;
    logic [XLEN-1:0]  link_addr;
    logic [NCTRL-1:0] ctrl_in;

    assign squashing   = (squash_reg != '0);
    assign accept_insn = !flush_i && !stall_i && !squashing && valid_i;
    assign taken       = jal_i | jalr_i | (branch_i & zero_i);
    assign target_calc = jalr_i ? (alu_result_i & ~XLEN'(1)) : (pc_i + imm_i);
    assign link_addr   = pc_i + XLEN'(4);

    // Writes to x0 are dropped here so MEM/WB never see them.
    assign ctrl_in = {reg_write_i & (rd_i != 5'd0), mem_read_i, mem_write_i, mem_to_reg_i};

    genvar gi;
    generate
        for (gi = 0; gi < NCTRL; gi++) begin : g_ctrl
            assign ctrl_next[gi] = flush_i ? 1'b0 :
                                   stall_i ? ctrl_reg[gi] :
                                   (accept_insn & ctrl_in[gi]);
        end
    endgenerate

    always_comb begin
        valid_next      = valid_reg;
        result_next     = result_reg;
        store_data_next = store_data_reg;
        rd_next         = rd_reg;
        funct3_next     = funct3_reg;
        target_next     = target_reg;
        squash_next     = squash_reg;
        redirect_next   = 1'b0;
        misaligned_next = 1'b0;

        if (flush_i) begin
            valid_next  = 1'b0;
            squash_next = '0;
        end else if (!stall_i) begin
            if (squashing) begin
                // Wrong-path slot: consumed as a bubble, even if it is itself a taken jump.
                squash_next = squash_reg - CW'(1);
                valid_next  = 1'b0;
            end else begin
                valid_next = valid_i;
                if (valid_i) begin
                    result_next     = (jal_i | jalr_i) ? link_addr : alu_result_i;
                    store_data_next = rs2_data_i;
                    rd_next         = rd_i;
                    funct3_next     = funct3_i;
                    if (taken) begin
                        redirect_next   = 1'b1;
                        target_next     = target_calc;
                        misaligned_next = target_calc[1];
                        squash_next     = SQ_LOAD;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            valid_reg      <= 1'b0;
            result_reg     <= '0;
            store_data_reg <= '0;
            rd_reg         <= '0;
            funct3_reg     <= '0;
            redirect_reg   <= 1'b0;
            target_reg     <= '0;
            misaligned_reg <= 1'b0;
            squash_reg     <= '0;
            ctrl_reg       <= '0;
        end else begin
            valid_reg      <= valid_next;
            result_reg     <= result_next;
            store_data_reg <= store_data_next;
            rd_reg         <= rd_next;
            funct3_reg     <= funct3_next;
            redirect_reg   <= redirect_next;
            target_reg     <= target_next;
            misaligned_reg <= misaligned_next;
            squash_reg     <= squash_next;
            ctrl_reg       <= ctrl_next;
        end
    end

    assign valid_o      = valid_reg;
    assign result_o     = result_reg;
    assign store_data_o = store_data_reg;
    assign rd_o         = rd_reg;
    assign funct3_o     = funct3_reg;
    assign redirect_o   = redirect_reg;
    assign target_o     = target_reg;
    assign misaligned_o = misaligned_reg;
    assign reg_write_o  = ctrl_reg[3];
    assign mem_read_o   = ctrl_reg[2];
    assign mem_write_o  = ctrl_reg[1];
    assign mem_to_reg_o = ctrl_reg[0];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a slot-level reference model is stepped on every
// accepted edge and compared each cycle, with literal expectations pinning key results.
module tb_ex_mem_stage;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b1;
    logic        stall_i, flush_i, valid_i, zero_i;
    logic [31:0] pc_i, imm_i, alu_result_i, rs2_data_i;
    logic [4:0]  rd_i;
    logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
    logic        branch_i, jal_i, jalr_i;
    logic [2:0]  funct3_i;

    logic        valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
    logic        redirect_o, misaligned_o;
    logic [31:0] result_o, store_data_o, target_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;

    ex_mem_stage #(.XLEN(32), .SQUASH_DEPTH(2)) dut (
        .CLK(CLK), .RST_n(RST_n), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .pc_i(pc_i), .imm_i(imm_i), .alu_result_i(alu_result_i),
        .zero_i(zero_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_to_reg_i(mem_to_reg_i), .branch_i(branch_i), .jal_i(jal_i), .jalr_i(jalr_i),
        .funct3_i(funct3_i), .valid_o(valid_o), .result_o(result_o),
        .store_data_o(store_data_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
        .funct3_o(funct3_o), .redirect_o(redirect_o), .target_o(target_o),
        .misaligned_o(misaligned_o)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit go = 0;

    // Reference model state: what the MEM stage should be showing, plus pending wrong-path slots.
    bit        e_valid, e_rw, e_mr, e_mw, e_m2r, e_redir, e_mis, tgt_known;
    bit [31:0] e_result, e_store, e_tgt;
    bit [4:0]  e_rd;
    bit [2:0]  e_f3;
    int        slots_to_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_redir = 0; e_mis = 0;
        e_result = 0; e_store = 0; e_tgt = 0; e_rd = 0; e_f3 = 0;
        tgt_known = 1; slots_to_drop = 0;
    endtask

    task automatic model_kill_controls();
        e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0;
    endtask

    task automatic model_edge();
        bit [31:0] dest;
        e_redir = 0;
        e_mis   = 0;
        if (flush_i) begin
            model_kill_controls();
            slots_to_drop = 0;
            tgt_known = 0;
        end else if (stall_i) begin
            // everything else is frozen
        end else if (slots_to_drop > 0) begin
            slots_to_drop--;
            model_kill_controls();
        end else if (!valid_i) begin
            model_kill_controls();
        end else begin
            e_valid  = 1;
            e_rw     = reg_write_i && (rd_i != 0);
            e_mr     = mem_read_i;
            e_mw     = mem_write_i;
            e_m2r    = mem_to_reg_i;
            e_rd     = rd_i;
            e_f3     = funct3_i;
            e_store  = rs2_data_i;
            e_result = (jal_i || jalr_i) ? pc_i + 32'd4 : alu_result_i;
            if (jal_i || jalr_i || (branch_i && zero_i)) begin
                dest = jalr_i ? {alu_result_i[31:1], 1'b0} : pc_i + imm_i;
                e_redir = 1;
                e_tgt   = dest;
                e_mis   = dest[1];
                tgt_known = 1;
                slots_to_drop = 2;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (go) begin
            chk("valid_o",      {31'd0, valid_o},      {31'd0, e_valid});
            chk("reg_write_o",  {31'd0, reg_write_o},  {31'd0, e_rw});
            chk("mem_read_o",   {31'd0, mem_read_o},   {31'd0, e_mr});
            chk("mem_write_o",  {31'd0, mem_write_o},  {31'd0, e_mw});
            chk("mem_to_reg_o", {31'd0, mem_to_reg_o}, {31'd0, e_m2r});
            chk("redirect_o",   {31'd0, redirect_o},   {31'd0, e_redir});
            chk("misaligned_o", {31'd0, misaligned_o}, {31'd0, e_mis});
            if (tgt_known) chk("target_o", target_o, e_tgt);
            if (e_valid) begin
                chk("result_o",     result_o,             e_result);
                chk("store_data_o", store_data_o,         e_store);
                chk("rd_o",         {27'd0, rd_o},        {27'd0, e_rd});
                chk("funct3_o",     {29'd0, funct3_o},    {29'd0, e_f3});
            end
        end
    end

    task automatic clr();
        valid_i = 0; pc_i = 0; imm_i = 0; alu_result_i = 0; zero_i = 0; rs2_data_i = 0;
        rd_i = 0; reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0;
        branch_i = 0; jal_i = 0; jalr_i = 0; funct3_i = 0;
    endtask

    task automatic op_alu(input logic [4:0] rd, input logic [31:0] alu);
        clr(); valid_i = 1; rd_i = rd; reg_write_i = 1; alu_result_i = alu;
    endtask

    task automatic op_br(input logic [31:0] pc, input logic [31:0] imm, input logic z);
        clr(); valid_i = 1; pc_i = pc; imm_i = imm; branch_i = 1; zero_i = z;
        alu_result_i = 32'h0000_0001;
    endtask

    task automatic op_jalr(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd);
        clr(); valid_i = 1; pc_i = pc; alu_result_i = alu; jalr_i = 1; rd_i = rd; reg_write_i = 1;
    endtask

    task automatic op_jal(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
        clr(); valid_i = 1; pc_i = pc; imm_i = imm; jal_i = 1; rd_i = rd; reg_write_i = 1;
        alu_result_i = 32'h0000_0BAD;
    endtask

    task automatic cycle(input string name);
        @(posedge CLK);
        model_edge();
        #1;
        $display("[%0t] %-12s st=%0d fl=%0d v=%0d rw=%0d redir=%0d tgt=%08h mis=%0d res=%08h",
                 $time, name, stall_i, flush_i, valid_o, reg_write_o, redirect_o,
                 target_o, misaligned_o, result_o);
    endtask

    initial begin
        clr();
        stall_i = 0;
        flush_i = 0;
        model_reset();
        #2 RST_n = 0;
        go = 1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("reset valid_o",    {31'd0, valid_o},    32'd0);
        chk("reset redirect_o", {31'd0, redirect_o}, 32'd0);
        chk("reset target_o",   target_o,            32'd0);
        chk("reset result_o",   result_o,            32'd0);
        #2 RST_n = 1;

        // Taken BEQ then the two wrong-path ADDs behind it
        op_br(32'h100, 32'h20, 1'b1);  cycle("beq_taken");
        chk("beq redirect", {31'd0, redirect_o}, 32'd1);
        chk("beq target",   target_o,            32'h120);
        chk("beq valid",    {31'd0, valid_o},    32'd1);
        chk("beq rw",       {31'd0, reg_write_o}, 32'd0);
        op_alu(5'd5, 32'h11);          cycle("add_sq1");
        chk("sq1 redirect", {31'd0, redirect_o}, 32'd0);
        chk("sq1 valid",    {31'd0, valid_o},    32'd0);
        chk("sq1 rw",       {31'd0, reg_write_o}, 32'd0);
        op_alu(5'd6, 32'h22);          cycle("add_sq2");
        chk("sq2 valid",    {31'd0, valid_o},    32'd0);
        op_alu(5'd7, 32'h33);          cycle("add_ok");
        chk("add3 valid",   {31'd0, valid_o},    32'd1);
        chk("add3 result",  result_o,            32'h33);

        // Stall right after a taken branch: registers and pending squash both hold
        op_br(32'h400, 32'hFFFF_FFF0, 1'b1); cycle("beq_back");
        chk("back target", target_o, 32'h3F0);
        op_alu(5'd8, 32'h44);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall redirect", {31'd0, redirect_o}, 32'd0);
            chk("stall valid",    {31'd0, valid_o},    32'd1);
        end
        stall_i = 0;
        cycle("add_sq1");
        chk("post-stall sq1 valid", {31'd0, valid_o}, 32'd0);
        op_alu(5'd9, 32'h55);          cycle("add_sq2");
        chk("post-stall sq2 valid", {31'd0, valid_o}, 32'd0);
        op_alu(5'd10, 32'h66);         cycle("add_ok");
        chk("post-stall valid", {31'd0, valid_o}, 32'd1);

        // JALR: aligned then misaligned target
        op_jalr(32'h200, 32'h3F5, 5'd1); cycle("jalr_a");
        chk("jalr target", target_o, 32'h3F4);
        chk("jalr result", result_o, 32'h204);
        chk("jalr mis",    {31'd0, misaligned_o}, 32'd0);
        chk("jalr rw",     {31'd0, reg_write_o},  32'd1);
        clr();                         cycle("idle_sq1");
        cycle("idle_sq2");
        op_jalr(32'h200, 32'h3F6, 5'd1); cycle("jalr_m");
        chk("jalr2 mis",    {31'd0, misaligned_o}, 32'd1);
        chk("jalr2 redir",  {31'd0, redirect_o},   32'd1);
        chk("jalr2 target", target_o,              32'h3F6);
        clr();                         cycle("idle_sq1");
        cycle("idle_sq2");

        // Not-taken branch, then a store
        op_br(32'h600, 32'h40, 1'b0);  cycle("beq_nt");
        chk("nt redirect", {31'd0, redirect_o}, 32'd0);
        chk("nt target",   target_o,            32'h3F6);
        clr(); valid_i = 1; alu_result_i = 32'h1004; rs2_data_i = 32'hDEAD_BEEF;
        mem_write_i = 1; funct3_i = 3'd2; cycle("sw");
        chk("sw valid", {31'd0, valid_o},     32'd1);
        chk("sw data",  store_data_o,         32'hDEAD_BEEF);
        chk("sw mw",    {31'd0, mem_write_o}, 32'd1);
        clr(); valid_i = 1; alu_result_i = 32'h2000; rd_i = 5'd12; reg_write_i = 1;
        mem_read_i = 1; mem_to_reg_i = 1; funct3_i = 3'd4; cycle("lbu");
        chk("lbu f3", {29'd0, funct3_o}, 32'd4);

        // Flush beats stall with a squash pending
        op_jal(32'h500, 32'h8, 5'd1);  cycle("jal");
        chk("jal target", target_o, 32'h508);
        chk("jal result", result_o, 32'h504);
        op_alu(5'd2, 32'h99);
        flush_i = 1; stall_i = 1;      cycle("flush+stall");
        chk("flush valid", {31'd0, valid_o},     32'd0);
        chk("flush rw",    {31'd0, reg_write_o}, 32'd0);
        flush_i = 0; stall_i = 0;
        op_alu(5'd3, 32'h77);          cycle("add_after");
        chk("after flush valid",  {31'd0, valid_o}, 32'd1);
        chk("after flush result", result_o,         32'h77);

        // A taken jump on the wrong path must not redirect
        op_br(32'h700, 32'h10, 1'b1);  cycle("beq_taken");
        op_jal(32'h704, 32'h100, 5'd1); cycle("jal_wrong");
        chk("wrong-path redirect", {31'd0, redirect_o}, 32'd0);
        chk("wrong-path target",   target_o,            32'h710);
        op_alu(5'd4, 32'h12);          cycle("add_sq2");
        op_alu(5'd4, 32'h13);          cycle("add_ok");
        chk("after wrong-path valid", {31'd0, valid_o}, 32'd1);

        // Asynchronous reset between edges while a squash is pending
        op_br(32'h800, 32'h40, 1'b1);  cycle("beq_taken");
        #2 RST_n = 0;
        model_reset();
        #1;
        chk("async valid",    {31'd0, valid_o},    32'd0);
        chk("async redirect", {31'd0, redirect_o}, 32'd0);
        chk("async target",   target_o,            32'd0);
        #2 RST_n = 1;
        op_alu(5'd0, 32'h5A);          cycle("add_x0");
        chk("x0 valid", {31'd0, valid_o},     32'd1);
        chk("x0 rw",    {31'd0, reg_write_o}, 32'd0);
        clr();                         cycle("idle");

        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
